// File: rtl/register_write_bank_pkg.sv
// Shared types and constants for the comparator register write bank.
package register_bank_pkg;

    localparam int unsigned NUM_REGS    = 31;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned REG_W       = 32;
    localparam int unsigned MATCH_W     = 32;
    localparam logic [REG_W-1:0] RESET_VALUE = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Latched write target from the match-vector encoder.
    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] index;
    } wr_target_t;

endpackage

// File: rtl/register_write_bank_if.sv
// Write/clear handshake and flattened register bus of register_write_bank.
// Optional WR_BITMASK_EN adds the per-bit write mask.
interface register_write_bank_if #(
    parameter int unsigned size_reg = 32,
    parameter int unsigned NUM_REGS = 31
) ();

    logic                         wr_valid;
    logic                         wr_ready;
    logic [31:0]                  wr_match;
    logic [size_reg-1:0]          wr_data;
`ifdef WR_BITMASK_EN
    logic [size_reg-1:0]          wr_mask;
`endif
    logic                         wr_done;
    logic                         wr_miss;
    logic                         clr_req;
    logic                         clr_done;
    logic [NUM_REGS*size_reg-1:0] regs_out;

    modport slave (
`ifdef WR_BITMASK_EN
        input  wr_mask,
`endif
        input  wr_valid, wr_match, wr_data, clr_req,
        output wr_ready, wr_done, wr_miss, clr_done, regs_out
    );

    modport master (
`ifdef WR_BITMASK_EN
        output wr_mask,
`endif
        output wr_valid, wr_match, wr_data, clr_req,
        input  wr_ready, wr_done, wr_miss, clr_done, regs_out
    );

endinterface

// File: rtl/register_write_bank_prio_index_enc.sv
// Lowest-set-bit encoder over the 31 comparator match bits.
module prio_index_enc
    import register_bank_pkg::*;
(
    input  logic [NUM_REGS-1:0] vec,
    output logic [IDX_W-1:0]    index,
    output logic                hit
);

    // Scan downward so the lowest set bit is the last assignment.
    always_comb begin
        index = '0;
        hit   = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDX_W'(i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_write_bank.sv
// Comparator register bank: match-selected single-register writes and a
// sequenced bulk clear. Define WR_BITMASK_EN for bit-masked writes.
module register_write_bank
    import register_bank_pkg::state_t, register_bank_pkg::IDLE,
           register_bank_pkg::WRITE, register_bank_pkg::CLEAR,
           register_bank_pkg::IDX_W, register_bank_pkg::wr_target_t;
#(
    parameter int unsigned         size_reg    = 32,
    parameter int unsigned         NUM_REGS    = 31,
    parameter logic [size_reg-1:0] RESET_VALUE = size_reg'(register_bank_pkg::RESET_VALUE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    register_write_bank_if.slave  bus
);

    state_t              state, state_nxt;
    logic [size_reg-1:0] regs [NUM_REGS];
    logic [size_reg-1:0] lat_data;
    logic [size_reg-1:0] wr_word;
    wr_target_t          lat_tgt;
    logic [IDX_W-1:0]    clr_idx;
    logic [IDX_W-1:0]    enc_index;
    logic                enc_hit;
    logic                accept_c;
    logic                clr_last;
    logic                done_q, miss_q, clr_done_q;
    logic                done_nxt, miss_nxt, clr_done_nxt;
    logic                match_unused;

    assign match_unused = bus.wr_match[31];

    prio_index_enc u_enc (
        .vec   (bus.wr_match[NUM_REGS-1:0]),
        .index (enc_index),
        .hit   (enc_hit)
    );

    assign clr_last     = (clr_idx == IDX_W'(NUM_REGS - 1));
    assign bus.wr_ready = (state == IDLE) && !bus.clr_req;
    assign bus.wr_done  = done_q;
    assign bus.wr_miss  = miss_q;
    assign bus.clr_done = clr_done_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus.regs_out[i*size_reg +: size_reg] = regs[i];
        end
    end

`ifdef WR_BITMASK_EN
    logic [size_reg-1:0] lat_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_mask <= '0;
        end else if (accept_c) begin
            lat_mask <= bus.wr_mask;
        end
    end

    assign wr_word = (regs[lat_tgt.index] & ~lat_mask) | (lat_data & lat_mask);
`else
    assign wr_word = lat_data;
`endif

    // Next-state and registered-pulse decode.
    always_comb begin
        state_nxt    = state;
        accept_c     = 1'b0;
        done_nxt     = 1'b0;
        miss_nxt     = 1'b0;
        clr_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = CLEAR;
                end else if (bus.wr_valid) begin
                    state_nxt = WRITE;
                    accept_c  = 1'b1;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
                done_nxt  = lat_tgt.hit;
                miss_nxt  = !lat_tgt.hit;
            end
            CLEAR: begin
                if (clr_last) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            miss_q     <= 1'b0;
            clr_done_q <= 1'b0;
            clr_idx    <= '0;
            lat_data   <= '0;
            lat_tgt    <= '0;
        end else begin
            state      <= state_nxt;
            done_q     <= done_nxt;
            miss_q     <= miss_nxt;
            clr_done_q <= clr_done_nxt;
            if (accept_c) begin
                lat_data      <= bus.wr_data;
                lat_tgt.hit   <= enc_hit;
                lat_tgt.index <= enc_index;
            end
            if (state == IDLE && bus.clr_req) begin
                clr_idx <= '0;
            end else if (state == CLEAR) begin
                clr_idx <= clr_last ? '0 : clr_idx + IDX_W'(1);
            end
        end
    end

    // Register array: one match-selected write or one clear step per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (state == WRITE && lat_tgt.hit) begin
            regs[lat_tgt.index] <= wr_word;
        end else if (state == CLEAR) begin
            regs[clr_idx] <= RESET_VALUE;
        end
    end

endmodule

// File: tb/tb_register_write_bank.sv
// Randomized bench for register_write_bank against a transaction-level model.
module tb_register_write_bank;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 31;
    localparam int unsigned CW = N * W;
    localparam logic [W-1:0] RV = 32'h0000_0001;

    logic clk = 1'b0;
    logic reset_n;

    register_write_bank_if #(.size_reg(W), .NUM_REGS(N)) bus ();

    register_write_bank #(.size_reg(W), .NUM_REGS(N), .RESET_VALUE(RV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_regs [N];
    logic         exp_ready, exp_done, exp_miss, exp_clr_done;
    logic         check_en;
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [CW-1:0] all_rv;

    function automatic logic [CW-1:0] pack_exp();
        logic [CW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = exp_regs[k];
        return v;
    endfunction

    function automatic int lowest_match(input logic [31:0] m);
        for (int k = 0; k < N; k++) if (m[k]) return k;
        return -1;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("regs_out", bus.regs_out, pack_exp());
            check("wr_ready", CW'(bus.wr_ready), CW'(exp_ready));
            check("wr_done",  CW'(bus.wr_done),  CW'(exp_done));
            check("wr_miss",  CW'(bus.wr_miss),  CW'(exp_miss));
            check("clr_done", CW'(bus.clr_done), CW'(exp_clr_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        exp_done     = 1'b0;
        exp_miss     = 1'b0;
        exp_clr_done = 1'b0;
    endtask

    task automatic idle();
        step();
        clear_pulses();
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) exp_regs[k] = RV;
        clear_pulses();
        exp_ready = 1'b1;
    endtask

    task automatic drive_mask(input logic [W-1:0] mk);
`ifdef WR_BITMASK_EN
        bus.wr_mask = mk;
`else
        if (mk == '0) bus.wr_data = bus.wr_data;
`endif
    endtask

    function automatic logic [W-1:0] rand_mask();
`ifdef WR_BITMASK_EN
        return W'($urandom);
`else
        return '1;
`endif
    endfunction

    // One write transaction: accept edge, then the write edge.
    task automatic do_write(input logic [31:0] m, input logic [W-1:0] d, input logic [W-1:0] mk);
        int k;
        k = lowest_match(m);
        bus.wr_valid = 1'b1;
        bus.wr_match = m;
        bus.wr_data  = d;
        drive_mask(mk);
        step();
        clear_pulses();
        exp_ready    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_match = $urandom;
        bus.wr_data  = $urandom;
        drive_mask(W'($urandom));
        step();
        if (k >= 0) exp_regs[k] = (exp_regs[k] & ~mk) | (d & mk);
        exp_done  = (k >= 0);
        exp_miss  = (k < 0);
        exp_ready = 1'b1;
    endtask

    // Bulk clear; abort_at >= 0 asserts reset while that index is pending.
    task automatic do_clear(input bit with_write, input int abort_at);
        bus.clr_req = 1'b1;
        if (with_write) begin
            bus.wr_valid = 1'b1;
            bus.wr_match = 32'h0000_0004;
            bus.wr_data  = $urandom;
        end
        exp_ready = 1'b0;
        step();
        clear_pulses();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i == abort_at) begin
                check_en    = 1'b0;
                reset_n     = 1'b0;
                bus.clr_req = 1'b0;
                model_reset();
                #1;
                check("abort_regs", bus.regs_out, all_rv);
                step();
                step();
                reset_n  = 1'b1;
                check_en = 1'b1;
                return;
            end
            step();
            exp_regs[i] = RV;
            if (i == int'(N) - 2) bus.clr_req = 1'b0;
            if (i == int'(N) - 1) begin
                exp_clr_done = 1'b1;
                exp_ready    = 1'b1;
            end
        end
    endtask

    initial begin
        int r;
        logic [31:0] m;
        all_rv       = {N{RV}};
        check_en     = 1'b0;
        reset_n      = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_match = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        drive_mask('0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        check_en = 1'b1;
        check("reset_regs", bus.regs_out, all_rv);
        check("reset_ready", CW'(bus.wr_ready), CW'(1'b1));

        do_write(32'h0000_0004, 32'hDEAD_BEEF, '1);
        check("r3_written", CW'(bus.regs_out[2*W +: W]), CW'(32'hDEAD_BEEF));
        check("r3_done", CW'(bus.wr_done), CW'(1'b1));
        check("model_r3", CW'(exp_regs[2]), CW'(32'hDEAD_BEEF));
        idle();

        do_write(32'h0000_0110, 32'h1234_5678, '1);
        check("r5_written", CW'(bus.regs_out[4*W +: W]), CW'(32'h1234_5678));
        check("r9_untouched", CW'(bus.regs_out[8*W +: W]), CW'(RV));
        idle();

        do_write(32'h8000_0000, 32'h5555_AAAA, '1);
        check("bit31_miss", CW'(bus.wr_miss), CW'(1'b1));
        check("bit31_no_done", CW'(bus.wr_done), CW'(1'b0));
        do_write(32'h0000_0000, 32'h6666_7777, '1);
        check("zero_miss", CW'(bus.wr_miss), CW'(1'b1));
        do_write(32'h4000_0000, 32'h0BAD_F00D, '1);
        check("r31_written", CW'(bus.regs_out[30*W +: W]), CW'(32'h0BAD_F00D));

        do_clear(1'b1, -1);
        check("clear_done", CW'(bus.clr_done), CW'(1'b1));
        check("clear_regs", bus.regs_out, all_rv);
        do_write(32'h0000_0004, 32'hDEAD_BEEF, '1);
        check("retry_r3", CW'(bus.regs_out[2*W +: W]), CW'(32'hDEAD_BEEF));
        idle();

`ifdef WR_BITMASK_EN
        do_write(32'h0000_0001, 32'hFFFF_0000, '1);
        do_write(32'h0000_0001, 32'h0000_ABCD, 32'h0000_FF00);
        check("mask_r1", CW'(bus.regs_out[W-1:0]), CW'(32'hFFFF_AB00));
        do_write(32'h0000_0001, 32'h1234_5678, 32'h0000_0000);
        check("mask0_done", CW'(bus.wr_done), CW'(1'b1));
        check("mask0_r1", CW'(bus.regs_out[W-1:0]), CW'(32'hFFFF_AB00));
        idle();
`endif

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_clear(1'($urandom), -1);
            end else if (r < 12) begin
                idle();
            end else begin
                case ($urandom_range(0, 3))
                    0:       m = 32'h1 << $urandom_range(0, 31);
                    1:       m = $urandom;
                    2:       m = '0;
                    default: m = $urandom & $urandom & $urandom;
                endcase
                do_write(m, W'($urandom), rand_mask());
            end
        end

        do_write(32'h0000_0800, 32'hCAFE_F00D, '1);
        check("r12_pre_abort", CW'(bus.regs_out[11*W +: W]), CW'(32'hCAFE_F00D));
        do_clear(1'b0, 10);
        check("abort_r12", CW'(bus.regs_out[11*W +: W]), CW'(RV));
        idle();
        idle();
        do_write(32'h0000_0002, 32'h0F0F_0F0F, '1);
        check("post_abort_r2", CW'(bus.regs_out[W +: W]), CW'(32'h0F0F_0F0F));
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/register_write_bank.md
Name: register_write_bank

Overview:
Write-side companion to the comparator read path. Holds the 31 comparator registers (r1..r31) and exposes them as one flattened bus for the existing read-select logic. Updates one register per write transaction. The target register is chosen by the comparator match vector: the lowest set bit wins, so bit k selects register r(k+1). It also provides a sequenced bulk clear. Sits between the host/bus-decoder write port and the comparator datapath.

Parameters:
- size_reg, 32: width of each register and of the write data.
- NUM_REGS, 31: number of registers. Fixed at 31; the parameter exists only for width derivation.
- RESET_VALUE, 32'h00000001: value loaded on reset and on clear. Matches the read path's no-match default.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  block can accept a write this cycle.
- wr_match  in  32  comparator match vector. Bits 0..30 map to r1..r31; bit 31 is ignored.
- wr_data  in  size_reg  write data.
- wr_done  out  1  one-cycle pulse: a register was written.
- wr_miss  out  1  one-cycle pulse: an accepted write had no valid match bit.
- clr_req  in  1  start a bulk clear (level sampled in IDLE).
- clr_done  out  1  one-cycle pulse at the end of a clear.
- regs_out  out  NUM_REGS*size_reg  flattened registers; r1 occupies bits [size_reg-1:0], r(n) occupies [n*size_reg-1:(n-1)*size_reg].

Behaviour:
- Reset (reset_n low, asynchronous):
  - All registers = RESET_VALUE; state = IDLE.
  - wr_done, wr_miss, clr_done = 0; clear index = 0.
  - wr_ready is combinational and evaluates to 1 once reset is released.
- States: IDLE, WRITE, CLEAR.
- wr_ready = (state==IDLE) && !clr_req. It is combinational and does not depend on wr_valid.
- IDLE:
  - If clr_req=1: go to CLEAR, index=0. Clear has priority; a simultaneous wr_valid is not accepted.
  - Else if wr_valid && wr_ready: latch wr_data and the priority-encoded index/hit of wr_match[30:0], then go to WRITE.
- WRITE (exactly 1 cycle):
  - If hit: register[index] <= latched data, and wr_done=1 on the following cycle.
  - If no hit (wr_match[30:0]==0): no register changes, and wr_miss=1 on the following cycle.
  - Return to IDLE.
- Write timing:
  - Register update is visible on regs_out 2 cycles after the accept edge.
  - Maximum throughput is one write per 2 cycles.
- CLEAR:
  - Each cycle, register[index] <= RESET_VALUE and index increments.
  - After index 30 is written: clr_done pulses 1 cycle, index wraps to 0, state returns to IDLE.
  - Total duration is 31 cycles; wr_ready=0 throughout.
  - clr_req is ignored while in CLEAR (no restart).
- Outputs: wr_done, wr_miss, clr_done are registered, mutually exclusive, and each high for exactly 1 cycle.
- Reset mid-operation: aborts immediately. All registers return to RESET_VALUE, including any partially cleared set or in-flight write. No done or miss pulse is produced.
- Multiple match bits: only the lowest index is written; other registers are untouched.
- wr_data and wr_match may change after the accept cycle without effect, because they are latched.

Optional Feature:
- Macro WR_BITMASK_EN.
- When defined:
  - Adds input wr_mask [size_reg-1:0], latched with wr_data at accept.
  - WRITE updates only the masked bits: reg <= (reg & ~mask) | (data & mask).
  - mask==0 still pulses wr_done with no data change.
  - CLEAR ignores the mask.
- When undefined: the port is absent and writes replace the full register.

Decomposition:
- Shared package (register_bank_pkg):
  - state enum IDLE/WRITE/CLEAR;
  - NUM_REGS=31 and index width 5;
  - RESET_VALUE default.
- Sub-module prio_index_enc: combinational 31-bit lowest-set-bit encoder with outputs index[4:0] and hit. Instantiated once on wr_match.

Test Plan:
- Reset release → all 31 regs = 0x00000001 and wr_ready=1. Assert reset_n=0 mid-CLEAR (index 10) → all regs 0x00000001, no clr_done.
- wr_match=0x00000004, data=0xDEADBEEF → r3=0xDEADBEEF two cycles after accept, wr_done 1 pulse, all other regs unchanged.
- wr_match=0x00000110, data=0x12345678 → only r5 written (lowest bit 4), r9 unchanged.
- wr_match=0x80000000 or 0 → wr_miss pulse, no register change, wr_done stays 0.
- clr_req and wr_valid in the same cycle → write not accepted. After clear, wr_ready=0 for 31 cycles and clr_done pulses once; all regs = 0x00000001; the retried write then succeeds.
- WR_BITMASK_EN build: r1=0xFFFF0000, write data=0x0000ABCD, mask=0x0000FF00 → r1=0xFFFFAB00.
